// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-wide slice of A + (B ^ sub) + cin; reused every RUN cycle.
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             sub,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout
);

    logic [DIGIT-1:0] b_eff;

    assign b_eff        = b_d ^ {DIGIT{sub}};
    assign {cout, s_d}  = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: LSB-first, DIGIT bits per clock, with
// valid/ready handshakes on both the operand and result sides.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int NSTEPS = WIDTH / DIGIT;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       a_sh, b_sh;
    logic                   mode_r, a_msb, b_msb, cy;
    logic [DIGIT-1:0]       s_d;
    logic                   cout;
    logic                   last;
    logic                   ovf_sign;
    logic [WIDTH+DIGIT-1:0] res_cat;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d  (a_sh[DIGIT-1:0]),
        .b_d  (b_sh[DIGIT-1:0]),
        .sub  (mode_r),
        .cin  (cy),
        .s_d  (s_d),
        .cout (cout)
    );

    assign last      = (cnt == CW'(NSTEPS - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    // New digit enters at the MSB end; slicing the concatenation also covers DIGIT == WIDTH.
    assign res_cat   = {s_d, result};
    // Operand sign agreement that makes a sign flip in the result an overflow.
    assign ovf_sign  = (mode_r == MODE_ADD) ? (a_msb == b_msb) : (a_msb != b_msb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            mode_r   <= MODE_ADD;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            cy       <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    mode_r <= mode;
                    a_msb  <= a[WIDTH-1];
                    b_msb  <= b[WIDTH-1];
                    cy     <= mode;  // subtract is A + ~B + 1
                    cnt    <= '0;
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    cy     <= cout;
                    cnt    <= cnt + CW'(1);
                    result <= res_cat[WIDTH+DIGIT-1:DIGIT];
                    if (last) begin
                        carry    <= (mode_r == MODE_SUB) ? ~cout : cout;
                        overflow <= ovf_sign && (s_d[DIGIT-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
